// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-port synchronous RAM shared by the fetch
// and data ports, one transaction in flight, data-first with a starve guard.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_data,
    input  logic        d_req_valid,
    output logic        d_req_ready,
    input  logic [31:0] d_req_addr,
    input  logic        d_req_we,
    input  logic [3:0]  d_req_be,
    input  logic [31:0] d_req_wdata,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_data,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q;
    logic [3:0]  starve_q;
    logic [1:0]  wait_q;
    logic        own_d_q;
    logic        we_q;
    logic        mem_en_q;
    logic [3:0]  mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        if_rsp_valid_q;
    logic [31:0] if_rsp_data_q;
    logic        d_rsp_valid_q;
    logic [31:0] d_rsp_data_q;

    logic force_if;
    logic d_win;
    logic if_win;
    logic unused_addr;

    // Byte offset bits never reach the word-addressed RAM.
    assign unused_addr = ^{if_req_addr[1:0], d_req_addr[1:0]};

    assign force_if = if_req_valid && (starve_q == 4'(STARVE_MAX));
    assign d_win    = (state_q == IDLE) && d_req_valid && !force_if;
    assign if_win   = (state_q == IDLE) && if_req_valid && !d_win;

    assign if_req_ready = if_win;
    assign d_req_ready  = d_win;
    assign if_rsp_valid = if_rsp_valid_q;
    assign if_rsp_data  = if_rsp_data_q;
    assign d_rsp_valid  = d_rsp_valid_q;
    assign d_rsp_data   = d_rsp_data_q;
    assign mem_en       = mem_en_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            wait_q         <= '0;
            own_d_q        <= 1'b0;
            we_q           <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= '0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            if_rsp_valid_q <= 1'b0;
            if_rsp_data_q  <= '0;
            d_rsp_valid_q  <= 1'b0;
            d_rsp_data_q   <= '0;
        end else begin
            if_rsp_valid_q <= 1'b0;
            d_rsp_valid_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!if_req_valid || if_win) begin
                        starve_q <= '0;
                    end else if (d_win && starve_q != 4'(STARVE_MAX)) begin
                        starve_q <= starve_q + 4'd1;
                    end
                    if (d_win) begin
                        own_d_q     <= 1'b1;
                        we_q        <= d_req_we;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= {d_req_addr[31:2], 2'b00};
                        mem_we_q    <= d_req_we ? d_req_be : 4'b0000;
                        mem_wdata_q <= d_req_wdata;
                        state_q     <= ISSUE;
                    end else if (if_win) begin
                        own_d_q     <= 1'b0;
                        we_q        <= 1'b0;
                        mem_en_q    <= 1'b1;
                        mem_addr_q  <= {if_req_addr[31:2], 2'b00};
                        mem_we_q    <= 4'b0000;
                        mem_wdata_q <= '0;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= '0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    if (own_d_q && we_q) begin
                        d_rsp_valid_q <= 1'b1;
                        d_rsp_data_q  <= '0;
                        state_q       <= RESP;
                    end else begin
                        wait_q  <= 2'(MEM_LAT - 1);
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (wait_q == 2'd0) begin
                        if (own_d_q) begin
                            d_rsp_valid_q <= 1'b1;
                            d_rsp_data_q  <= mem_rdata;
                        end else begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_data_q  <= mem_rdata;
                        end
                        state_q <= RESP;
                    end else begin
                        wait_q <= wait_q - 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random traffic against a
// transaction-level model of arbitration, latency and memory contents.
module tb_mem_port_arbiter;

    localparam int LAT  = 3;
    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [3:0]  d_req_be;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready),
        .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready),
        .d_req_addr(d_req_addr), .d_req_we(d_req_we),
        .d_req_be(d_req_be), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // RAM behind the DUT: garbage on rdata except the one valid cycle
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val;
    logic [31:0] garbage;
    logic [31:0] ram [64];
    logic        pv [LAT];
    logic [31:0] pd [LAT];

    assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : garbage;

    always @(posedge clk) begin
        garbage <= $urandom;
        if (ld_en) begin
            ram[ld_idx] <= ld_val;
        end else if (mem_en && mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        pv[0] <= mem_en && (mem_we == 4'b0000);
        pd[0] <= ram[mem_addr[7:2]];
        for (int k = 1; k < LAT; k++) begin
            pv[k] <= pv[k-1];
            pd[k] <= pd[k-1];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    int cyc = 0;
    int nxt_acc = 0;
    int iss_cyc = -1;
    int rsp_cyc = -1;
    int losses = 0;
    bit rsp_d;
    bit e_st;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rsp;
    logic [3:0]  e_we;
    logic [31:0] ref_mem [64];
    bit took_if;
    bit took_d;
    byte gq[$];
    int last_if_cyc;
    int last_d_cyc;
    int if_cnt = 0;
    logic [31:0] last_if_data;
    logic [31:0] last_d_data;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model();
        bit idle;
        bit force_f;
        bit dwin;
        bit fwin;
        logic [31:0] w;
        logic [5:0] idx;
        took_if = if_req_valid && if_req_ready;
        took_d  = d_req_valid && d_req_ready;
        if (if_rsp_valid) begin
            last_if_cyc  = cyc;
            last_if_data = if_rsp_data;
            if_cnt++;
        end
        if (d_rsp_valid) begin
            last_d_cyc  = cyc;
            last_d_data = d_rsp_data;
        end
        if (rst) begin
            nxt_acc = cyc + 1;
            iss_cyc = -1;
            rsp_cyc = -1;
            losses  = 0;
            return;
        end
        idle    = cyc >= nxt_acc;
        force_f = idle && if_req_valid && losses >= SMAX;
        dwin    = idle && d_req_valid && !force_f;
        fwin    = idle && if_req_valid && !dwin;
        chk("if_ready", {31'b0, if_req_ready}, {31'b0, fwin});
        chk("d_ready", {31'b0, d_req_ready}, {31'b0, dwin});
        if (cyc == iss_cyc) begin
            chk("mem_en", {31'b0, mem_en}, 32'd1);
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", {28'b0, mem_we}, {28'b0, e_we});
            if (e_st) chk("mem_wdata", mem_wdata, e_wdata);
        end else begin
            chk("mem_en_idle", {31'b0, mem_en}, 32'd0);
            chk("mem_quiet", mem_addr | mem_wdata | {28'b0, mem_we}, 32'd0);
        end
        chk("if_rsp_valid", {31'b0, if_rsp_valid}, {31'b0, cyc == rsp_cyc && !rsp_d});
        chk("d_rsp_valid", {31'b0, d_rsp_valid}, {31'b0, cyc == rsp_cyc && rsp_d});
        if (cyc == rsp_cyc) begin
            if (rsp_d) chk("d_rsp_data", d_rsp_data, e_rsp);
            else chk("if_rsp_data", if_rsp_data, e_rsp);
        end
        if (idle && !if_req_valid) losses = 0;
        else if (fwin) losses = 0;
        else if (dwin) losses++;
        if (dwin || fwin) begin
            w       = dwin ? d_req_addr : if_req_addr;
            idx     = w[7:2];
            iss_cyc = cyc + 1;
            rsp_d   = dwin;
            e_addr  = {w[31:2], 2'b00};
            e_st    = dwin && d_req_we;
            e_we    = e_st ? d_req_be : 4'b0000;
            e_wdata = d_req_wdata;
            if (e_st) begin
                for (int b = 0; b < 4; b++)
                    if (d_req_be[b]) ref_mem[idx][8*b +: 8] = d_req_wdata[8*b +: 8];
                e_rsp   = 32'd0;
                rsp_cyc = cyc + 2;
                nxt_acc = cyc + 3;
            end else begin
                e_rsp   = ref_mem[idx];
                rsp_cyc = cyc + LAT + 2;
                nxt_acc = cyc + LAT + 3;
            end
            gq.push_back(dwin ? 8'h44 : 8'h46);
        end
    endtask

    task automatic step();
        #2;
        model();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic gen(int pif, int pd_);
        if (!if_req_valid || took_if) begin
            if_req_valid = int'($urandom_range(0, 99)) < pif;
            if_req_addr  = $urandom;
        end
        if (!d_req_valid || took_d) begin
            d_req_valid = int'($urandom_range(0, 99)) < pd_;
            d_req_addr  = $urandom;
            d_req_we    = 1'($urandom_range(0, 1));
            d_req_be    = 4'($urandom);
            d_req_wdata = $urandom;
        end
    endtask

    task automatic quiet(string tag);
        #1;
        chk({tag, "_rdy"}, {30'b0, if_req_ready, d_req_ready}, 32'd0);
        chk({tag, "_rspv"}, {30'b0, if_rsp_valid, d_rsp_valid}, 32'd0);
        chk({tag, "_rspd"}, if_rsp_data | d_rsp_data, 32'd0);
        chk({tag, "_mem"}, mem_addr | mem_wdata | {27'b0, mem_en, mem_we}, 32'd0);
    endtask

    task automatic dreq(input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, output int acc);
        d_req_valid = 1'b1;
        d_req_addr  = a;
        d_req_we    = we;
        d_req_be    = be;
        d_req_wdata = wd;
        acc = cyc;
        for (int i = 0; i < 20; i++) begin
            acc = cyc;
            step();
            if (took_d) break;
        end
        chk("d_accept", {31'b0, took_d}, 32'd1);
        d_req_valid = 1'b0;
        repeat (LAT + 4) step();
    endtask

    task automatic drain();
        if_req_valid = 1'b0;
        d_req_valid  = 1'b0;
        repeat (LAT + 5) step();
    endtask

    task automatic fetch_once(input logic [31:0] a, input string tag, input logic [31:0] exp);
        int acc;
        if_req_valid = 1'b1;
        if_req_addr  = a;
        acc = cyc;
        #1;
        chk({tag, "_rdy"}, {31'b0, if_req_ready}, 32'd1);
        step();
        if_req_valid = 1'b0;
        repeat (LAT + 4) step();
        chk({tag, "_lat"}, 32'(last_if_cyc - acc), 32'(LAT + 2));
        chk({tag, "_data"}, last_if_data, exp);
    endtask

    initial begin
        string e;
        int acc;
        int cnt0;
        bit was_idle;
        rst = 1'b1;
        ld_en = 1'b0;
        ld_idx = '0;
        ld_val = '0;
        if_req_valid = 1'b0;
        if_req_addr = '0;
        d_req_valid = 1'b0;
        d_req_addr = '0;
        d_req_we = 1'b0;
        d_req_be = '0;
        d_req_wdata = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) begin
            ld_en  = 1'b1;
            ld_idx = 6'(i);
            ld_val = (i == 4) ? 32'h00500093 : (i == 8) ? 32'h11223344 : $urandom;
            ref_mem[i] = ld_val;
            step();
        end
        ld_en = 1'b0;
        step();
        rst = 1'b0;
        quiet("reset");
        step();

        fetch_once(32'h10, "fetch", 32'h00500093);

        dreq(32'h23, 1'b1, 4'b0011, 32'hAABBCCDD, acc);
        chk("st_lat", 32'(last_d_cyc - acc), 32'd2);
        chk("st_data", last_d_data, 32'd0);
        dreq(32'h20, 1'b0, 4'b0000, 32'h0, acc);
        chk("ld_lat", 32'(last_d_cyc - acc), 32'(LAT + 2));
        chk("ld_merge", last_d_data, 32'h1122CCDD);

        drain();
        gq.delete();
        gen(100, 100);
        for (int i = 0; i < 120 && gq.size() < 6; i++) begin
            step();
            gen(100, 100);
        end
        e = "DDDDFD";
        for (int i = 0; i < 6; i++)
            chk("grant", (i < gq.size()) ? 32'(gq[i]) : 32'd0, 32'(e[i]));

        drain();
        gq.delete();
        gen(100, 100);
        for (int i = 0; i < 60 && gq.size() < 2; i++) begin
            step();
            gen(100, 100);
        end
        if_req_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            was_idle = cyc >= nxt_acc;
            step();
            gen(0, 100);
            if (was_idle) break;
        end
        if_req_valid = 1'b1;
        for (int i = 0; i < 150 && gq.size() < 8; i++) begin
            step();
            gen(100, 100);
        end
        e = "DDDDDDDF";
        for (int i = 0; i < 8; i++)
            chk("grant_clr", (i < gq.size()) ? 32'(gq[i]) : 32'd0, 32'(e[i]));

        drain();
        if_req_valid = 1'b1;
        if_req_addr  = 32'h40;
        step();
        chk("rw_acc", {31'b0, took_if}, 32'd1);
        if_req_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        cnt0 = if_cnt;
        quiet("rst_wait");
        step();
        repeat (LAT + 3) step();
        chk("rw_no_rsp", 32'(if_cnt - cnt0), 32'd0);
        fetch_once(32'h12, "refetch", 32'h00500093);

        gen(40, 50);
        for (int i = 0; i < 600; i++) begin
            step();
            gen(40, 50);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port synchronous memory between the core's instruction-fetch port and data load/store port. The core memory interface is split into separate fetch and data ports; this block lets both be served from one physical RAM with a fixed read latency. It accepts one request at a time over valid/ready, issues it to the memory, and returns a one-cycle response pulse to the winning requester. Data accesses win by default, and a starvation guard ensures fetch cannot be locked out.

Parameters:
MEM_LAT, 1, memory read latency in cycles from the mem_en cycle to mem_rdata valid; legal range 1..4.
STARVE_MAX, 4, consecutive lost arbitrations with fetch valid after which fetch is forced to win; legal range 1..15.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
if_req_valid  in  1  fetch request
if_req_ready  out  1  fetch request accepted this cycle
if_req_addr  in  32  fetch byte address
if_rsp_valid  out  1  fetch data valid, one-cycle pulse
if_rsp_data  out  32  fetch instruction word
d_req_valid  in  1  data request
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  32  data byte address
d_req_we  in  1  1 = store, 0 = load
d_req_be  in  4  store byte enables
d_req_wdata  in  32  store data
d_rsp_valid  out  1  load data valid or store done, one-cycle pulse
d_rsp_data  out  32  load data; 0 for stores
mem_en  out  1  memory access strobe
mem_we  out  4  per-byte write enable
mem_addr  out  32  word-aligned address
mem_wdata  out  32  store data to memory
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset state is IDLE.
- Reset values: all outputs 0, starvation counter 0, latched request cleared.
- IDLE:
  - Ready outputs are combinational; only the arbitration winner sees ready=1, and only in IDLE.
  - Winner selection: data wins if d_req_valid=1, unless starve_cnt==STARVE_MAX and if_req_valid=1, in which case fetch wins. Otherwise fetch wins if if_req_valid=1.
  - On a handshake, latch addr, we, be, wdata and the owner, then go to ISSUE.
  - No valid request: stay in IDLE.
- Starvation counter (4 bit):
  - Increments when data wins while if_req_valid=1.
  - Clears when fetch wins, or whenever if_req_valid=0 in IDLE.
  - Saturates at STARVE_MAX.
- ISSUE (1 cycle):
  - mem_en=1.
  - mem_addr = {addr[31:2], 2'b00}; addr[1:0] is ignored.
  - mem_we = be if the latched request is a store, else 0.
  - mem_wdata = latched wdata.
  - Store: go to RESP. Load/fetch: go to WAIT.
  - mem_en, mem_we, mem_addr and mem_wdata are 0 in every other state.
- WAIT (MEM_LAT cycles, down-counter):
  - In the last WAIT cycle, sample mem_rdata into the response register, then go to RESP.
- RESP (1 cycle):
  - The owner's rsp_valid=1 and rsp_data = captured word; a store returns 0.
  - The non-owner's rsp_valid stays 0.
  - Go to IDLE.
- Timing (accept in cycle 0):
  - Load/fetch: response in cycle MEM_LAT+2, next accept no earlier than cycle MEM_LAT+3.
  - Store: response in cycle 2, next accept in cycle 3.
- Requesters hold valid and payload stable until ready. Payload changes while ready=0 have no effect. Requests are never dropped.
- rsp_data holds its last value outside RESP; the bench checks it only when rsp_valid=1.
- rst=1 in any state: IDLE on the next edge. In-flight access is abandoned, no response is issued, and the counter is cleared. A store already issued to memory is not undone.
- Exactly one outstanding transaction at a time; no pipelining.

Test Plan:
- Fetch only, MEM_LAT=1: if_req_addr=0x10 with mem word 4 = 0x00500093, valid at cycle 0 -> if_req_ready=1 in cycle 0; mem_en=1 with mem_addr=0x10 in cycle 1; if_rsp_valid=1 with if_rsp_data=0x00500093 in cycle 3.
- Store then load: store d_req_addr=0x23 (word 8, since addr[1:0] is ignored), be=4'b0011, wdata=0xAABBCCDD -> mem_we=4'b0011 and mem_addr=0x20 in cycle 1, d_rsp_valid=1 with d_rsp_data=0 in cycle 2. A following load of 0x20 returns the low halfword merged with prior contents.
- Contention, STARVE_MAX=4: both valid continuously -> grant order data, data, data, data, fetch, data..., checked by the ready sequence.
- Starvation clear: fetch loses twice, drops valid for one IDLE cycle, reasserts -> counter reset; fetch waits another 4 data grants.
- MEM_LAT=3: fetch response exactly in cycle 5; mem_rdata held at garbage in cycles 2-3 and valid only in cycle 4 -> the correct word is captured.
- Reset in WAIT with a fetch in flight -> no if_rsp_valid pulse; all outputs 0 the cycle after reset; a new fetch is served normally.
